// File: rtl/mipi_tx_pkg.sv
// D-PHY transmit shared definitions: lane state encoding, LP line levels, HS byte patterns.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Shared by the clock-lane controller and the data-lane transmitter.
package mipi_tx_pkg;

    typedef enum logic [3:0] {
        ST_STOP      = 4'd0,
        ST_HS_RQST   = 4'd1,
        ST_BRIDGE    = 4'd2,
        ST_HS_ZERO   = 4'd3,
        ST_HS_PRE    = 4'd4,
        ST_HS_CLK    = 4'd5,
        ST_HS_POST   = 4'd6,
        ST_HS_TRAIL  = 4'd7,
        ST_HS_EXIT   = 4'd8,
        ST_ULPS_RQST = 4'd9,
        ST_ULPS      = 4'd10,
        ST_ULPS_EXIT = 4'd11
    } clk_state_t;

    // LP line levels packed as {lp_p, lp_n}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [7:0] HS_ZERO_BYTE = 8'h00;
    // Alternating bits starting with 1: every byte boundary is a rising phase
    localparam logic [7:0] HS_CLK_BYTE  = 8'h55;

endpackage

// File: rtl/mipi_tx_timer.sv
// Loadable down-counter: done is high while the count is zero.
// Latency: load takes effect on the next clk edge; done is combinational from the count.
// Backpressure: none; load overrides counting.
// Ports: clk, rst (sync active-high), load, load_val[CNT_W], done.
module mipi_tx_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mipi_clk_lane_tx.sv
// D-PHY clock-lane TX controller: LP-11/01/00 -> HS-0 -> toggle -> trail -> LP-11 handshake.
// Latency: all outputs registered, changing on the same edge as the state register.
// Backpressure: none; hs_req is a level sampled only in STOP and HS_CLK.
// Ports: clk, rst (sync active-high), hs_req, ulps_req -> hs_byte[8], hs_oe, lp_p, lp_n,
//        clk_active, idle, ulps_active.
// Build option: define MIPI_CLK_ULPS_EN to include the ULPS entry/exit states.
module mipi_clk_lane_tx
    import mipi_tx_pkg::*;
#(
    parameter int T_LPX     = 4,
    parameter int T_PREPARE = 2,
    parameter int T_ZERO    = 16,
    parameter int T_PRE     = 2,
    parameter int T_POST    = 8,
    parameter int T_TRAIL   = 4,
    parameter int T_HS_EXIT = 6,
    parameter int T_WAKEUP  = 1000,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic       ulps_req,
    output logic [7:0] hs_byte,
    output logic       hs_oe,
    output logic       lp_p,
    output logic       lp_n,
    output logic       clk_active,
    output logic       idle,
    output logic       ulps_active
);

    clk_state_t       state, state_nxt;
    logic             tmr_done;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;

    logic [1:0] lp_nxt;
    logic       oe_nxt, act_nxt, idle_nxt, ulps_nxt;
    logic [7:0] byte_nxt;

`ifndef MIPI_CLK_ULPS_EN
    logic unused_ulps_req;
    assign unused_ulps_req = ulps_req;
`endif

    // Timer reload value for a state lasting max(T,1) cycles: done fires on its last cycle
    function automatic logic [CNT_W-1:0] dur(input clk_state_t s);
        int t;
        case (s)
            ST_HS_RQST, ST_ULPS_RQST: t = T_LPX;
            ST_BRIDGE:                t = T_PREPARE;
            ST_HS_ZERO:               t = T_ZERO;
            ST_HS_PRE:                t = T_PRE;
            ST_HS_POST:               t = T_POST;
            ST_HS_TRAIL:              t = T_TRAIL;
            ST_HS_EXIT:               t = T_HS_EXIT;
            ST_ULPS_EXIT:             t = T_WAKEUP;
            default:                  t = 1;
        endcase
        return (t <= 1) ? '0 : CNT_W'(t - 1);
    endfunction

    mipi_tx_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: begin
                if (hs_req) begin
                    state_nxt = ST_HS_RQST;
`ifdef MIPI_CLK_ULPS_EN
                end else if (ulps_req) begin
                    state_nxt = ST_ULPS_RQST;
`endif
                end
            end
            ST_HS_RQST:  if (tmr_done) state_nxt = ST_BRIDGE;
            ST_BRIDGE:   if (tmr_done) state_nxt = ST_HS_ZERO;
            ST_HS_ZERO:  if (tmr_done) state_nxt = ST_HS_PRE;
            ST_HS_PRE:   if (tmr_done) state_nxt = ST_HS_CLK;
            ST_HS_CLK:   if (!hs_req)  state_nxt = ST_HS_POST;
            ST_HS_POST:  if (tmr_done) state_nxt = ST_HS_TRAIL;
            ST_HS_TRAIL: if (tmr_done) state_nxt = ST_HS_EXIT;
            ST_HS_EXIT:  if (tmr_done) state_nxt = ST_STOP;
`ifdef MIPI_CLK_ULPS_EN
            ST_ULPS_RQST: if (tmr_done)  state_nxt = ST_ULPS;
            ST_ULPS:      if (!ulps_req) state_nxt = ST_ULPS_EXIT;
            ST_ULPS_EXIT: if (tmr_done)  state_nxt = ST_STOP;
`endif
            default: state_nxt = ST_STOP;
        endcase
    end

    // Timer restarts on every state change
    assign tmr_load = (state_nxt != state);
    assign tmr_val  = dur(state_nxt);

    // Output decode from the next state so outputs register alongside the state
    always_comb begin
        lp_nxt   = LP11;
        oe_nxt   = 1'b0;
        byte_nxt = HS_ZERO_BYTE;
        act_nxt  = 1'b0;
        idle_nxt = 1'b0;
        ulps_nxt = 1'b0;
        case (state_nxt)
            ST_STOP:     idle_nxt = 1'b1;
            ST_HS_RQST:  lp_nxt = LP01;
            ST_BRIDGE:   lp_nxt = LP00;
            ST_HS_ZERO, ST_HS_TRAIL: begin
                lp_nxt = LP00;
                oe_nxt = 1'b1;
            end
            ST_HS_PRE, ST_HS_POST: begin
                lp_nxt   = LP00;
                oe_nxt   = 1'b1;
                byte_nxt = HS_CLK_BYTE;
            end
            ST_HS_CLK: begin
                lp_nxt   = LP00;
                oe_nxt   = 1'b1;
                byte_nxt = HS_CLK_BYTE;
                act_nxt  = 1'b1;
            end
            ST_HS_EXIT:  lp_nxt = LP11;
`ifdef MIPI_CLK_ULPS_EN
            ST_ULPS_RQST, ST_ULPS_EXIT: lp_nxt = LP10;
            ST_ULPS: begin
                lp_nxt   = LP00;
                ulps_nxt = 1'b1;
            end
`endif
            default: idle_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_STOP;
            hs_byte     <= HS_ZERO_BYTE;
            hs_oe       <= 1'b0;
            lp_p        <= 1'b1;
            lp_n        <= 1'b1;
            clk_active  <= 1'b0;
            idle        <= 1'b1;
            ulps_active <= 1'b0;
        end else begin
            state       <= state_nxt;
            hs_byte     <= byte_nxt;
            hs_oe       <= oe_nxt;
            lp_p        <= lp_nxt[1];
            lp_n        <= lp_nxt[0];
            clk_active  <= act_nxt;
            idle        <= idle_nxt;
            ulps_active <= ulps_nxt;
        end
    end

endmodule
